// File: rtl/wb_pwm_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pwm_bank_pkg
// Brief   : Register map, decode kinds and byte-lane helpers for wb_pwm_bank.
// Revision: 1.0
// ============================================================================
package wb_pwm_bank_pkg;

  localparam int C_ADR_CTRL   = 'h00;
  localparam int C_ADR_STATUS = 'h01;
  localparam int C_CH_BASE    = 'h10;
  localparam int C_CH_STRIDE  = 4;
  localparam int C_OFS_PERIOD = 0;
  localparam int C_OFS_DUTY   = 1;
  localparam int C_OFS_COUNT  = 2;

  typedef enum logic [2:0] {
    RK_NONE   = 3'd0,
    RK_CTRL   = 3'd1,
    RK_STATUS = 3'd2,
    RK_PERIOD = 3'd3,
    RK_DUTY   = 3'd4,
    RK_COUNT  = 3'd5
  } reg_kind_e;

  function automatic int ch_adr(input int ch, input int ofs);
    return C_CH_BASE + ch * C_CH_STRIDE + ofs;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pwm_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_pwm_bank_if
// Brief   : Classic Wishbone bus bundle between the fabric bridge and the PWM bank.
// Revision: 1.0
// ============================================================================
interface wb_pwm_bank_if #(
  parameter int ADR_W = 15
);
  logic [ADR_W-1:0] wb_adr;
  logic [31:0]      wb_dat_w;
  logic [31:0]      wb_dat_r;
  logic [3:0]       wb_sel;
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic             wb_ack;
  logic             wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/wb_pwm_bank_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : wb_pwm_bank_pwm_channel
// Brief   : One PWM channel; active period/duty reload only on the wrap edge.
// Revision: 1.0
// ============================================================================
module wb_pwm_bank_pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en_i,
  input  logic             inv_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_per_q, act_per_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic             pwm_q, pwm_d;
  logic             w_wrap;
  logic             w_raw;

  always_comb begin
    cnt_d      = cnt_q;
    act_per_d  = act_per_q;
    act_duty_d = act_duty_q;
    w_wrap     = en_i && (cnt_q == act_per_q);
    w_raw      = en_i && (cnt_q < act_duty_q);
    // A disabled channel keeps tracking the shadows so enabling starts clean.
    if (!en_i || w_wrap) begin
      cnt_d      = '0;
      act_per_d  = period_i;
      act_duty_d = duty_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pwm_d = w_raw ^ inv_i;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      act_per_q  <= '0;
      act_duty_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_per_q  <= act_per_d;
      act_duty_q <= act_duty_d;
      pwm_q      <= pwm_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = w_wrap;
  assign pwm_o  = pwm_q;

endmodule
`default_nettype wire

// File: rtl/wb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module  : wb_pwm_bank
// Brief   : Wishbone slave PWM bank with double-buffered period/duty per channel.
// Revision: 1.0
// ============================================================================
module wb_pwm_bank
  import wb_pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16,
  parameter int ADR_W  = 15
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  wb_pwm_bank_if.slave      wb,
  output logic [NUM_CH-1:0] pwm
);

  logic [NUM_CH-1:0]            en_q, en_d;
  logic [NUM_CH-1:0]            inv_q, inv_d;
  logic [NUM_CH-1:0]            wrap_q, wrap_d;
  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_q, duty_d;
  logic                         ack_q, ack_d;
  logic                         err_q, err_d;
  logic [31:0]                  dat_r_q, dat_r_d;

  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_CH-1:0]            w_wrap;
  logic [NUM_CH-1:0]            w_per_hit;
  logic [NUM_CH-1:0]            w_duty_hit;
  logic [NUM_CH-1:0]            w_w1c;
  reg_kind_e                    w_kind;
  logic [31:0]                  w_rdata;
  logic [31:0]                  w_ctrl_word;
  logic                         w_req;
  logic                         w_hit;
  logic                         w_wr;

  assign w_ctrl_word = {16'h0000, 8'(inv_q), 8'(en_q)};

  always_comb begin
    w_kind     = RK_NONE;
    w_rdata    = '0;
    w_per_hit  = '0;
    w_duty_hit = '0;
    if (wb.wb_adr == ADR_W'(C_ADR_CTRL)) begin
      w_kind  = RK_CTRL;
      w_rdata = w_ctrl_word;
    end else if (wb.wb_adr == ADR_W'(C_ADR_STATUS)) begin
      w_kind  = RK_STATUS;
      w_rdata = 32'(wrap_q);
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (wb.wb_adr == ADR_W'(ch_adr(n, C_OFS_PERIOD))) begin
        w_kind       = RK_PERIOD;
        w_per_hit[n] = 1'b1;
        w_rdata      = 32'(period_q[n]);
      end
      if (wb.wb_adr == ADR_W'(ch_adr(n, C_OFS_DUTY))) begin
        w_kind        = RK_DUTY;
        w_duty_hit[n] = 1'b1;
        w_rdata       = 32'(duty_q[n]);
      end
      if (wb.wb_adr == ADR_W'(ch_adr(n, C_OFS_COUNT))) begin
        w_kind  = RK_COUNT;
        w_rdata = 32'(w_cnt[n]);
      end
    end
  end

  // ack/err gate the next request, so a held strobe is served every 2nd cycle.
  assign w_req = wb.wb_cyc & wb.wb_stb & ~ack_q & ~err_q;
  assign w_hit = (w_kind != RK_NONE);
  assign w_wr  = w_req & w_hit & wb.wb_we;
  assign w_w1c = (w_wr && (w_kind == RK_STATUS) && wb.wb_sel[0]) ?
                 wb.wb_dat_w[NUM_CH-1:0] : '0;

  always_comb begin
    en_d     = en_q;
    inv_d    = inv_q;
    period_d = period_q;
    duty_d   = duty_q;
    ack_d    = w_req & w_hit;
    err_d    = w_req & ~w_hit;
    dat_r_d  = (w_req && w_hit && !wb.wb_we) ? w_rdata : '0;
    if (w_wr && (w_kind == RK_CTRL)) begin
      if (wb.wb_sel[0]) en_d  = wb.wb_dat_w[NUM_CH-1:0];
      if (wb.wb_sel[1]) inv_d = wb.wb_dat_w[8 +: NUM_CH];
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_wr && w_per_hit[n]) begin
        period_d[n] = CNT_W'(byte_merge(32'(period_q[n]), wb.wb_dat_w, wb.wb_sel));
      end
      if (w_wr && w_duty_hit[n]) begin
        duty_d[n] = CNT_W'(byte_merge(32'(duty_q[n]), wb.wb_dat_w, wb.wb_sel));
      end
    end
    // A wrap on the same edge as a clear keeps the flag set.
    wrap_d = w_wrap | (wrap_q & ~w_w1c);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      en_q     <= '0;
      inv_q    <= '0;
      wrap_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_r_q  <= '0;
    end else begin
      en_q     <= en_d;
      inv_q    <= inv_d;
      wrap_q   <= wrap_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_r_q  <= dat_r_d;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign wb.wb_dat_r = dat_r_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    wb_pwm_bank_pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en_i      (en_q[n]),
      .inv_i     (inv_q[n]),
      .period_i  (period_q[n]),
      .duty_i    (duty_q[n]),
      .cnt_o     (w_cnt[n]),
      .wrap_o    (w_wrap[n]),
      .pwm_o     (pwm[n])
    );
  end

endmodule
`default_nettype wire
